// File: rtl/reg_alu_sequencer_if.sv
// Instruction-stream interface for reg_alu_sequencer.
// Carries the instruction word and its valid/ready handshake, plus the
// cancel strobe that abandons a pending two-word (immediate) instruction.
//   instr_in     instruction header or immediate word, INSTR_W bits
//   instr_valid  source has a word on instr_in this cycle
//   instr_ready  sequencer takes instr_in on the next rising edge
//   cancel       drop the immediate instruction waiting for its second word
// Modports: master = instruction source, slave = sequencer.
interface reg_alu_sequencer_if #(
  parameter int ADDR_W = 4
);
  localparam int INSTR_W = 3*ADDR_W + 4;

  logic [INSTR_W-1:0] instr_in;
  logic               instr_valid;
  logic               instr_ready;
  logic               cancel;

  modport master (
    output instr_in,
    output instr_valid,
    output cancel,
    input  instr_ready
  );

  modport slave (
    input  instr_in,
    input  instr_valid,
    input  cancel,
    output instr_ready
  );
endinterface

// File: rtl/reg_alu_sequencer.sv
// reg_alu_sequencer
// Control-side driver for a register-file/ALU datapath. Accepts instructions
// over the ibus handshake, drives the datapath controls for one execute
// cycle, captures ALUResult and counts retired instructions.
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   ibus              instruction stream (slave side)
//   ALUResult         combinational result from the datapath
//   RA1, RA2, WA      register addresses to the datapath
//   RegWrite          write enable, high only during the execute cycle
//   ALUSrc            0: SrcB = RD2, 1: SrcB = external_data_in
//   ALUControl        ALU operation select
//   external_data_in  immediate operand
//   result            ALUResult captured at the end of the execute cycle
//   result_valid      one-cycle pulse when result is updated
//   retired           wrapping count of executed instructions
// Header word layout, MSB first: [op:2][imm:1][we:1][WA][RA1][RA2].
module reg_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_alu_sequencer_if.slave   ibus,
  input  logic [DATA_W-1:0]    ALUResult,
  output logic [ADDR_W-1:0]    RA1,
  output logic [ADDR_W-1:0]    RA2,
  output logic [ADDR_W-1:0]    WA,
  output logic                 RegWrite,
  output logic                 ALUSrc,
  output logic [1:0]           ALUControl,
  output logic [DATA_W-1:0]    external_data_in,
  output logic [DATA_W-1:0]    result,
  output logic                 result_valid,
  output logic [CNT_W-1:0]     retired
);
  localparam int INSTR_W = 3*ADDR_W + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMM  = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   we_q;
  logic   xfer;

  // Ready is a function of state and cancel only; a cancelled IMM word is
  // refused so it cannot be mistaken for the immediate.
  assign ibus.instr_ready = (state == IDLE) || ((state == IMM) && !ibus.cancel);
  assign xfer             = ibus.instr_valid && ibus.instr_ready;

  // Combinational so that an asynchronous reset drops the write at once.
  assign RegWrite = (state == EXEC) && we_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer) state_nxt = ibus.instr_in[INSTR_W-3] ? IMM : EXEC;
      IMM: begin
        if (ibus.cancel)   state_nxt = IDLE;
        else if (xfer)     state_nxt = EXEC;
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RA1              <= '0;
      RA2              <= '0;
      WA               <= '0;
      we_q             <= 1'b0;
      ALUSrc           <= 1'b0;
      ALUControl       <= 2'b00;
      external_data_in <= '0;
      result           <= '0;
      result_valid     <= 1'b0;
      retired          <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        // Decode: header fields go straight into the output registers.
        IDLE: begin
          if (xfer) begin
            ALUControl <= ibus.instr_in[INSTR_W-1 -: 2];
            ALUSrc     <= ibus.instr_in[INSTR_W-3];
            we_q       <= ibus.instr_in[INSTR_W-4];
            WA         <= ibus.instr_in[3*ADDR_W-1 -: ADDR_W];
            RA1        <= ibus.instr_in[2*ADDR_W-1 -: ADDR_W];
            RA2        <= ibus.instr_in[ADDR_W-1:0];
          end
        end
        // Immediate: only the low DATA_W bits of the second word matter.
        IMM: begin
          if (xfer) external_data_in <= ibus.instr_in[DATA_W-1:0];
        end
        // Execute: datapath writes on this same edge; capture and retire.
        EXEC: begin
          result       <= ALUResult;
          result_valid <= 1'b1;
          retired      <= retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
